// File: rtl/cond_pkg.sv
// ---------------------------------------------------------------------------
// cond_pkg
// Shared types and constants for the conditional-execution controller.
//   cond_e       : 4-bit ARM-style condition field encodings (EQ..AL, NV).
//   FLAG_*       : bit positions of N, Z, C, V inside the {N,Z,C,V} vector.
//   FW_*         : bit positions inside the 2-bit flag-write request.
//   cond_state_e : controller states.
// ---------------------------------------------------------------------------
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // in_flag_w[1] owns the N/Z pair, in_flag_w[0] owns the C/V pair
    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;

    typedef enum logic [0:0] {
        ST_IDLE       = 1'b0,
        ST_WAIT_FLAGS = 1'b1
    } cond_state_e;

endpackage

// File: rtl/cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval
// Purely combinational condition evaluator.
//   i_cond    [3:0] : condition field
//   i_flags   [3:0] : {N,Z,C,V}
//   o_cond_ex       : 1 when the instruction should execute; 0 for NV (1111)
// ---------------------------------------------------------------------------
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_cond_ex
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;
    logic w_ge;

    assign w_n  = i_flags[FLAG_N];
    assign w_z  = i_flags[FLAG_Z];
    assign w_c  = i_flags[FLAG_C];
    assign w_v  = i_flags[FLAG_V];
    assign w_ge = (w_n == w_v);

    always_comb begin
        o_cond_ex = 1'b0;
        case (cond_e'(i_cond))
            COND_EQ: o_cond_ex = w_z;
            COND_NE: o_cond_ex = !w_z;
            COND_CS: o_cond_ex = w_c;
            COND_CC: o_cond_ex = !w_c;
            COND_MI: o_cond_ex = w_n;
            COND_PL: o_cond_ex = !w_n;
            COND_VS: o_cond_ex = w_v;
            COND_VC: o_cond_ex = !w_v;
            COND_HI: o_cond_ex = w_c && !w_z;
            COND_LS: o_cond_ex = !(w_c && !w_z);
            COND_GE: o_cond_ex = w_ge;
            COND_LT: o_cond_ex = !w_ge;
            COND_GT: o_cond_ex = !w_z && w_ge;
            COND_LE: o_cond_ex = !(!w_z && w_ge);
            COND_AL: o_cond_ex = 1'b1;
            COND_NV: o_cond_ex = 1'b0;
            default: o_cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_exec_ctrl.sv
// ---------------------------------------------------------------------------
// cond_exec_ctrl
// Conditional-execution controller sitting between decode and execute.
// Holds the architectural NZCV register, evaluates each accepted instruction's
// condition against it, squashes the side effects of failed instructions and
// stalls issue while a flag-setting instruction's ALU flags are outstanding.
//
// Ports
//   clk, reset_n                 : clock, synchronous active-low reset
//   in_valid / in_ready          : decode handshake (in_ready is combinational)
//   in_cond, in_flag_w           : condition field, {update NZ, update CV}
//   in_reg_w, in_mem_w, in_pcs   : raw side-effect controls from decode
//   out_valid / out_ready        : execute handshake, single output register
//   out_reg_w, out_mem_w, out_pcs: side-effect controls gated by the condition
//   out_cond_ex                  : registered condition result
//   alu_flags_valid, alu_flags   : flag return from the ALU for the pending op
//   flags                        : architectural {N,Z,C,V}
//   cond_undef                   : pulse after accepting a cond=1111 instruction
//   flag_timeout                 : pulse after the flag watchdog aborts a wait
// ---------------------------------------------------------------------------
module cond_exec_ctrl
    import cond_pkg::*;
#(
    parameter int FLAG_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_cond,
    input  logic [1:0] in_flag_w,
    input  logic       in_reg_w,
    input  logic       in_mem_w,
    input  logic       in_pcs,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_reg_w,
    output logic       out_mem_w,
    output logic       out_pcs,
    output logic       out_cond_ex,
    input  logic       alu_flags_valid,
    input  logic [3:0] alu_flags,
    output logic [3:0] flags,
    output logic       cond_undef,
    output logic       flag_timeout
);

    localparam int WDOG_W = $clog2(FLAG_TIMEOUT);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(FLAG_TIMEOUT - 1);

    cond_state_e       r_state;
    logic [1:0]        r_pend_fw;
    logic [WDOG_W-1:0] r_wdog;
    logic [3:0]        r_flags;
    logic              r_out_valid;
    logic              r_out_reg_w;
    logic              r_out_mem_w;
    logic              r_out_pcs;
    logic              r_out_cond_ex;
    logic              r_cond_undef;
    logic              r_flag_timeout;

    logic w_cond_ex;
    logic w_waiting;
    logic w_hazard;
    logic w_out_free;
    logic w_in_ready;
    logic w_xfer;
    logic w_expire;

    // Only the committed flags feed evaluation; the ALU return is never bypassed.
    cond_eval u_cond_eval (
        .i_cond    (in_cond),
        .i_flags   (r_flags),
        .o_cond_ex (w_cond_ex)
    );

    assign w_waiting  = (r_state == ST_WAIT_FLAGS);
    // While flags are owed, only unconditional non-flag-setting work may pass:
    // anything else would either read stale flags or queue a second update.
    assign w_hazard   = w_waiting && ((in_cond != COND_AL) || (in_flag_w != 2'b00));
    assign w_out_free = !r_out_valid || out_ready;
    assign w_in_ready = w_out_free && !w_hazard;
    assign w_xfer     = in_valid && w_in_ready;
    // The watchdog aborts at the end of the FLAG_TIMEOUT-th waiting cycle;
    // a flag return arriving in that same cycle takes priority.
    assign w_expire   = w_waiting && !alu_flags_valid && (r_wdog == WDOG_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_pend_fw      <= 2'b00;
            r_wdog         <= '0;
            r_flags        <= 4'b0000;
            r_out_valid    <= 1'b0;
            r_out_reg_w    <= 1'b0;
            r_out_mem_w    <= 1'b0;
            r_out_pcs      <= 1'b0;
            r_out_cond_ex  <= 1'b0;
            r_cond_undef   <= 1'b0;
            r_flag_timeout <= 1'b0;
        end else begin
            r_cond_undef   <= w_xfer && (in_cond == COND_NV);
            r_flag_timeout <= w_expire;

            if (w_out_free) begin
                r_out_valid <= w_xfer;
            end
            if (w_xfer) begin
                r_out_reg_w   <= in_reg_w && w_cond_ex;
                r_out_mem_w   <= in_mem_w && w_cond_ex;
                r_out_pcs     <= in_pcs && w_cond_ex;
                r_out_cond_ex <= w_cond_ex;
            end

            if (r_state == ST_IDLE) begin
                // A failed instruction never owes a flag update.
                if (w_xfer && w_cond_ex && (in_flag_w != 2'b00)) begin
                    r_state   <= ST_WAIT_FLAGS;
                    r_pend_fw <= in_flag_w;
                    r_wdog    <= '0;
                end
            end else begin
                if (alu_flags_valid) begin
                    if (r_pend_fw[FW_NZ]) begin
                        r_flags[FLAG_N:FLAG_Z] <= alu_flags[FLAG_N:FLAG_Z];
                    end
                    if (r_pend_fw[FW_CV]) begin
                        r_flags[FLAG_C:FLAG_V] <= alu_flags[FLAG_C:FLAG_V];
                    end
                    r_state <= ST_IDLE;
                end else if (w_expire) begin
                    r_state <= ST_IDLE;
                end else begin
                    r_wdog <= r_wdog + 1'b1;
                end
            end
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = r_out_valid;
    assign out_reg_w    = r_out_reg_w;
    assign out_mem_w    = r_out_mem_w;
    assign out_pcs      = r_out_pcs;
    assign out_cond_ex  = r_out_cond_ex;
    assign flags        = r_flags;
    assign cond_undef   = r_cond_undef;
    assign flag_timeout = r_flag_timeout;

endmodule

// File: tb/tb_cond_exec_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cond_exec_ctrl
// Directed bench for cond_exec_ctrl. A main instance (default watchdog) runs
// against a cycle-level reference model plus literal expectations; a second
// instance with FLAG_TIMEOUT=4 exercises the watchdog with literal checks.
// ---------------------------------------------------------------------------
module tb_cond_exec_ctrl;

    localparam int MAIN_TIMEOUT = 64;
    localparam int SHORT_TIMEOUT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_cond = 4'he;
    logic [1:0] in_flag_w = 2'b00;
    logic       in_reg_w = 1'b0;
    logic       in_mem_w = 1'b0;
    logic       in_pcs = 1'b0;
    logic       out_ready = 1'b1;
    logic       alu_flags_valid = 1'b0;
    logic [3:0] alu_flags = 4'b0000;
    logic       in_ready, out_valid, out_reg_w, out_mem_w, out_pcs, out_cond_ex;
    logic [3:0] flags;
    logic       cond_undef, flag_timeout;

    // short-watchdog instance
    logic       t_in_valid = 1'b0;
    logic [3:0] t_in_cond = 4'he;
    logic [1:0] t_in_flag_w = 2'b00;
    logic       t_alu_flags_valid = 1'b0;
    logic [3:0] t_alu_flags = 4'b0000;
    logic       t_in_ready, t_out_valid, t_out_reg_w, t_out_mem_w, t_out_pcs, t_out_cond_ex;
    logic [3:0] t_flags;
    logic       t_cond_undef, t_flag_timeout;

    cond_exec_ctrl #(.FLAG_TIMEOUT(MAIN_TIMEOUT)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_cond(in_cond), .in_flag_w(in_flag_w),
        .in_reg_w(in_reg_w), .in_mem_w(in_mem_w), .in_pcs(in_pcs),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_reg_w(out_reg_w), .out_mem_w(out_mem_w), .out_pcs(out_pcs),
        .out_cond_ex(out_cond_ex),
        .alu_flags_valid(alu_flags_valid), .alu_flags(alu_flags),
        .flags(flags), .cond_undef(cond_undef), .flag_timeout(flag_timeout)
    );

    cond_exec_ctrl #(.FLAG_TIMEOUT(SHORT_TIMEOUT)) u_dut_to (
        .clk(clk), .reset_n(reset_n),
        .in_valid(t_in_valid), .in_ready(t_in_ready),
        .in_cond(t_in_cond), .in_flag_w(t_in_flag_w),
        .in_reg_w(1'b1), .in_mem_w(1'b0), .in_pcs(1'b0),
        .out_valid(t_out_valid), .out_ready(1'b1),
        .out_reg_w(t_out_reg_w), .out_mem_w(t_out_mem_w), .out_pcs(t_out_pcs),
        .out_cond_ex(t_out_cond_ex),
        .alu_flags_valid(t_alu_flags_valid), .alu_flags(t_alu_flags),
        .flags(t_flags), .cond_undef(t_cond_undef), .flag_timeout(t_flag_timeout)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Condition semantics: pairs share a base test, odd encodings invert it.
    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, r;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        if (c == 4'hf) return 1'b0;
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        return (c[0] && c != 4'he) ? !r : r;
    endfunction

    bit         m_init = 1'b0;
    bit         m_busy = 1'b0;     // a flag update is owed
    logic [1:0] m_owed = 2'b00;
    int         m_waited = 0;      // waiting cycles elapsed, counting the current one
    logic [3:0] m_flags = 4'b0000;
    bit         m_ov = 1'b0, m_oreg = 1'b0, m_omem = 1'b0, m_opcs = 1'b0, m_oce = 1'b0;
    bit         m_undef = 1'b0, m_tout = 1'b0;

    function automatic bit m_ready();
        bit blocked;
        blocked = m_busy && !(in_cond == 4'he && in_flag_w == 2'b00);
        return (!m_ov || out_ready) && !blocked;
    endfunction

    always @(posedge clk) begin : model
        bit x, ce;
        if (!reset_n) begin
            m_init <= 1'b1; m_busy <= 1'b0; m_owed <= 2'b00; m_waited <= 0;
            m_flags <= 4'b0000; m_ov <= 1'b0; m_oreg <= 1'b0; m_omem <= 1'b0;
            m_opcs <= 1'b0; m_oce <= 1'b0; m_undef <= 1'b0; m_tout <= 1'b0;
        end else begin
            x  = in_valid && m_ready();
            ce = cond_holds(in_cond, m_flags);
            if (x) $display("txn cond=%h flag_w=%b reg_w=%b mem_w=%b pcs=%b flags=%b exec=%0d",
                            in_cond, in_flag_w, in_reg_w, in_mem_w, in_pcs, m_flags, ce);
            if (!m_ov || out_ready) m_ov <= x;
            if (x) begin
                m_oreg <= in_reg_w && ce;
                m_omem <= in_mem_w && ce;
                m_opcs <= in_pcs && ce;
                m_oce  <= ce;
            end
            m_undef <= x && (in_cond == 4'hf);
            m_tout  <= 1'b0;
            if (m_busy) begin
                if (alu_flags_valid) begin
                    if (m_owed[1]) m_flags[3:2] <= alu_flags[3:2];
                    if (m_owed[0]) m_flags[1:0] <= alu_flags[1:0];
                    m_busy <= 1'b0;
                end else if (m_waited == MAIN_TIMEOUT) begin
                    m_busy <= 1'b0;
                    m_tout <= 1'b1;
                end else begin
                    m_waited <= m_waited + 1;
                end
            end else if (x && ce && in_flag_w != 2'b00) begin
                m_busy   <= 1'b1;
                m_owed   <= in_flag_w;
                m_waited <= 1;
            end
        end
    end

    always @(negedge clk) begin : compare
        if (m_init) begin
            chk1("model.in_ready", in_ready, m_ready());
            chk1("model.out_valid", out_valid, m_ov);
            chk4("model.flags", flags, m_flags);
            chk1("model.cond_undef", cond_undef, m_undef);
            chk1("model.flag_timeout", flag_timeout, m_tout);
            if (m_ov) begin
                chk1("model.out_reg_w", out_reg_w, m_oreg);
                chk1("model.out_mem_w", out_mem_w, m_omem);
                chk1("model.out_pcs", out_pcs, m_opcs);
                chk1("model.out_cond_ex", out_cond_ex, m_oce);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] c, input logic [1:0] fw,
                         input logic rw, input logic mw, input logic pcs);
        in_valid = 1'b1; in_cond = c; in_flag_w = fw;
        in_reg_w = rw; in_mem_w = mw; in_pcs = pcs;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic set_flags(input logic [3:0] f);
        drive(4'he, 2'b11, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        alu_flags_valid = 1'b1; alu_flags = f;
        tick();
        alu_flags_valid = 1'b0;
    endtask

    initial begin
        // reset held three cycles
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        chk4("reset.flags", flags, 4'b0000);
        chk1("reset.out_valid", out_valid, 1'b0);
        chk1("reset.in_ready", in_ready, 1'b1);
        chk1("reset.cond_undef", cond_undef, 1'b0);
        chk1("reset.flag_timeout", flag_timeout, 1'b0);

        // flags=0100: EQ executes, NE is squashed
        set_flags(4'b0100);
        chk4("z_set.flags", flags, 4'b0100);
        drive(4'h0, 2'b00, 1'b1, 1'b0, 1'b0);
        tick(); idle();
        chk1("eq.out_valid", out_valid, 1'b1);
        chk1("eq.out_reg_w", out_reg_w, 1'b1);
        chk1("eq.out_cond_ex", out_cond_ex, 1'b1);
        drive(4'h1, 2'b00, 1'b1, 1'b0, 1'b0);
        tick(); idle();
        chk1("ne.out_valid", out_valid, 1'b1);
        chk1("ne.out_reg_w", out_reg_w, 1'b0);
        chk1("ne.out_cond_ex", out_cond_ex, 1'b0);

        // AL flag-setter, GT stalls until flags return on the 5th waiting cycle
        drive(4'he, 2'b11, 1'b0, 1'b0, 1'b0);
        tick();
        drive(4'hc, 2'b00, 1'b1, 1'b0, 1'b0);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk1("gt_stall.in_ready", in_ready, 1'b0);
            tick();
        end
        alu_flags_valid = 1'b1; alu_flags = 4'b0000;
        #1;
        chk1("gt_stall5.in_ready", in_ready, 1'b0);
        tick();
        alu_flags_valid = 1'b0;
        #1;
        chk4("gt_ret.flags", flags, 4'b0000);
        chk1("gt_ret.in_ready", in_ready, 1'b1);
        tick(); idle();
        chk1("gt.out_valid", out_valid, 1'b1);
        chk1("gt.out_cond_ex", out_cond_ex, 1'b1);
        chk1("gt.out_reg_w", out_reg_w, 1'b1);

        // partial update: NZ only, CV preserved; AL non-setter passes mid-wait
        set_flags(4'b0011);
        chk4("cv_set.flags", flags, 4'b0011);
        drive(4'he, 2'b10, 1'b0, 1'b0, 1'b0);
        tick();
        drive(4'he, 2'b00, 1'b1, 1'b0, 1'b0);
        #1;
        chk1("al_pass.in_ready", in_ready, 1'b1);
        tick(); idle();
        chk1("al_pass.out_valid", out_valid, 1'b1);
        chk1("al_pass.out_reg_w", out_reg_w, 1'b1);
        alu_flags_valid = 1'b1; alu_flags = 4'b1100;
        tick();
        alu_flags_valid = 1'b0;
        chk4("nz_only.flags", flags, 4'b1111);

        // output back-pressure holds the register
        drive(4'he, 2'b00, 1'b1, 1'b1, 1'b0);
        tick();
        out_ready = 1'b0;
        drive(4'h4, 2'b00, 1'b0, 1'b0, 1'b1);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk1("hold.in_ready", in_ready, 1'b0);
            chk1("hold.out_valid", out_valid, 1'b1);
            chk1("hold.out_reg_w", out_reg_w, 1'b1);
            chk1("hold.out_mem_w", out_mem_w, 1'b1);
            chk1("hold.out_pcs", out_pcs, 1'b0);
            if (i < 2) tick();
        end
        out_ready = 1'b1;
        #1;
        chk1("release.in_ready", in_ready, 1'b1);
        tick(); idle();
        chk1("mi.out_pcs", out_pcs, 1'b1);
        chk1("mi.out_mem_w", out_mem_w, 1'b0);

        // undefined condition: accepted, gated off, pulse, no flag wait
        drive(4'hf, 2'b11, 1'b1, 1'b1, 1'b1);
        tick(); idle();
        chk1("nv.cond_undef", cond_undef, 1'b1);
        chk1("nv.out_valid", out_valid, 1'b1);
        chk1("nv.out_reg_w", out_reg_w, 1'b0);
        chk1("nv.out_mem_w", out_mem_w, 1'b0);
        chk1("nv.out_pcs", out_pcs, 1'b0);
        chk1("nv.out_cond_ex", out_cond_ex, 1'b0);
        drive(4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        #1;
        chk1("nv_nostall.in_ready", in_ready, 1'b1);
        tick(); idle();
        chk1("nv_pulse_end.cond_undef", cond_undef, 1'b0);
        chk1("eq_z1.out_cond_ex", out_cond_ex, 1'b1);

        // flag return while idle is ignored
        alu_flags_valid = 1'b1; alu_flags = 4'b0000;
        tick();
        alu_flags_valid = 1'b0;
        chk4("idle_alu.flags", flags, 4'b1111);

        // reset while waiting drops the pending update
        drive(4'he, 2'b11, 1'b0, 1'b0, 1'b0);
        tick(); idle();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        drive(4'hc, 2'b00, 1'b0, 1'b0, 1'b0);
        #1;
        chk1("rst_wait.in_ready", in_ready, 1'b1);
        chk4("rst_wait.flags", flags, 4'b0000);
        idle();
        alu_flags_valid = 1'b1; alu_flags = 4'b1111;
        tick();
        alu_flags_valid = 1'b0;
        chk4("rst_wait_alu.flags", flags, 4'b0000);

        // watchdog on the FLAG_TIMEOUT=4 instance
        t_in_valid = 1'b1; t_in_cond = 4'he; t_in_flag_w = 2'b11;
        tick();
        t_in_cond = 4'hc; t_in_flag_w = 2'b00;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk1("wd_wait.flag_timeout", t_flag_timeout, 1'b0);
            chk1("wd_wait.in_ready", t_in_ready, 1'b0);
            tick();
        end
        #1;
        chk1("wd_fire.flag_timeout", t_flag_timeout, 1'b1);
        chk1("wd_fire.in_ready", t_in_ready, 1'b1);
        chk4("wd_fire.flags", t_flags, 4'b0000);
        tick();
        t_in_valid = 1'b0;
        #1;
        chk1("wd_after.flag_timeout", t_flag_timeout, 1'b0);
        chk1("wd_after.out_cond_ex", t_out_cond_ex, 1'b1);

        // flag return in the last waiting cycle beats the watchdog
        t_in_valid = 1'b1; t_in_cond = 4'he; t_in_flag_w = 2'b11;
        tick();
        t_in_valid = 1'b0;
        repeat (3) tick();
        t_alu_flags_valid = 1'b1; t_alu_flags = 4'b1010;
        tick();
        t_alu_flags_valid = 1'b0;
        #1;
        chk1("wd_race.flag_timeout", t_flag_timeout, 1'b0);
        chk4("wd_race.flags", t_flags, 4'b1010);
        tick();
        chk1("wd_race_late.flag_timeout", t_flag_timeout, 1'b0);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
